// File: rtl/gf180mcu_invz_arb_pkg.sv
// Shared types and constants for the invz shared-bus arbiter.
package gf180mcu_invz_arb_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_DRIVE, ST_TURN} arb_state_e;
  localparam int GNT_W = 3;
  localparam int MAX_N = 8;
endpackage

// File: rtl/gf180mcu_invz_rr_pick.sv
// Combinational round-robin finder: first set bit at or after ptr, wrapping mod N.
module gf180mcu_invz_rr_pick #(
  parameter int N     = 4,
  parameter int PTR_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic             valid,
  output logic [PTR_W-1:0] idx
);
  logic [PTR_W:0] k;

  // Walk from the farthest offset down so the nearest set bit wins last.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    k     = '0;
    for (int i = N-1; i >= 0; i--) begin
      k = {1'b0, ptr} + (PTR_W+1)'(i);
      if (k >= (PTR_W+1)'(N)) k = k - (PTR_W+1)'(N);
      if (req[k[PTR_W-1:0]]) begin
        valid = 1'b1;
        idx   = k[PTR_W-1:0];
      end
    end
  end
endmodule

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__invz_bus_arb.sv
// Round-robin owner selection and break-before-make EN sequencing for N invz
// drivers on one net; keeper enabled whenever no driver is on.
module gf180mcu_fd_sc_mcu7t5v0__invz_bus_arb
  import gf180mcu_invz_arb_pkg::*;
#(
  parameter int N        = 4,
  parameter int TURN     = 1,
  parameter int MAX_HOLD = 16
) (
  input  logic             CLK,
  input  logic             RN,
  input  logic [N-1:0]     REQ,
  output logic [N-1:0]     EN,
  output logic [GNT_W-1:0] GNT_ID,
  output logic             BUSY,
  output logic             KEEPER_EN,
  output logic             PREEMPT,
  inout  wire              VDD,
  inout  wire              VSS
);
  localparam int PTR_W  = (N > 1) ? $clog2(N) : 1;
  localparam int HOLD_W = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = (MAX_HOLD > 0) ? HOLD_W'(MAX_HOLD - 1) : '1;
  localparam logic [1:0]        TURN_LAST = 2'(TURN - 1);

  arb_state_e        state, state_n;
  logic [N-1:0]      en_n;
  logic [GNT_W-1:0]  gnt_n;
  logic              busy_n, pre_n, arb, expire;
  logic [PTR_W-1:0]  ptr, ptr_n, gnt_idx, gnt_inc;
  logic [HOLD_W-1:0] hold, hold_n;
  logic [1:0]        turn_cnt, turn_n;
  logic              pick_valid;
  logic [PTR_W-1:0]  pick_idx;

  logic unused_supply;
  assign unused_supply = VDD ^ VSS;

  gf180mcu_invz_rr_pick #(.N(N), .PTR_W(PTR_W)) u_pick (
    .req   (REQ),
    .ptr   (ptr),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  assign gnt_idx = GNT_ID[PTR_W-1:0];
  assign gnt_inc = (gnt_idx == PTR_W'(N - 1)) ? '0 : gnt_idx + 1'b1;
  assign expire  = (MAX_HOLD != 0) && (hold == HOLD_LAST);

  always_comb begin
    state_n = state;
    en_n    = EN;
    gnt_n   = GNT_ID;
    busy_n  = BUSY;
    pre_n   = 1'b0;
    ptr_n   = ptr;
    hold_n  = hold;
    turn_n  = turn_cnt;
    arb     = 1'b0;
    case (state)
      ST_IDLE: arb = 1'b1;
      ST_DRIVE: begin
        if (!REQ[gnt_idx] || expire) begin
          en_n    = '0;
          busy_n  = 1'b0;
          ptr_n   = gnt_inc;
          turn_n  = '0;
          state_n = ST_TURN;
          // A simultaneous release is not a preemption.
          pre_n   = REQ[gnt_idx] & expire;
        end else if (hold != '1) begin
          hold_n = hold + 1'b1;
        end
      end
      ST_TURN: begin
        if (turn_cnt == TURN_LAST) begin
          state_n = ST_IDLE;
          arb     = 1'b1;
        end else begin
          turn_n = turn_cnt + 1'b1;
        end
      end
      default: state_n = ST_IDLE;
    endcase
    // Last turnaround cycle and IDLE share the grant path so EN rises on the edge ending TURN.
    if (arb && pick_valid) begin
      en_n           = '0;
      en_n[pick_idx] = 1'b1;
      gnt_n          = GNT_W'(pick_idx);
      busy_n         = 1'b1;
      hold_n         = '0;
      state_n        = ST_DRIVE;
    end
  end

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      state     <= ST_IDLE;
      EN        <= '0;
      GNT_ID    <= '0;
      BUSY      <= 1'b0;
      KEEPER_EN <= 1'b1;
      PREEMPT   <= 1'b0;
      ptr       <= '0;
      hold      <= '0;
      turn_cnt  <= '0;
    end else begin
      state     <= state_n;
      EN        <= en_n;
      GNT_ID    <= gnt_n;
      BUSY      <= busy_n;
      KEEPER_EN <= ~|en_n;
      PREEMPT   <= pre_n;
      ptr       <= ptr_n;
      hold      <= hold_n;
      turn_cnt  <= turn_n;
    end
  end

  a_en_onehot: assert property (@(posedge CLK) disable iff (!RN) $onehot0(EN));
  a_no_direct_handoff: assert property (@(posedge CLK) disable iff (!RN)
    (($past(EN) != '0) && (EN != '0)) |-> (EN == $past(EN)));
endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu7t5v0__invz_bus_arb.sv
// Scoreboarded bench: directed grant sequences on a 4-way arbiter plus a
// randomized fairness/safety run on an 8-way, TURN=3 instance.
module tb_gf180mcu_fd_sc_mcu7t5v0__invz_bus_arb;
  logic       CLK = 1'b0;
  logic       RN  = 1'b1;
  logic [3:0] REQ = '0;
  logic [3:0] EN;
  logic [2:0] GNT_ID;
  logic       BUSY, KEEPER_EN, PREEMPT;
  logic [7:0] REQ2 = '0;
  logic [7:0] EN2;
  logic [2:0] GNT_ID2;
  logic       BUSY2, KEEPER2, PRE2;
  wire        VDD, VSS;
  assign VDD = 1'b1;
  assign VSS = 1'b0;

  always #5 CLK = ~CLK;

  gf180mcu_fd_sc_mcu7t5v0__invz_bus_arb #(.N(4), .TURN(1), .MAX_HOLD(16)) dut (
    .CLK(CLK), .RN(RN), .REQ(REQ), .EN(EN), .GNT_ID(GNT_ID), .BUSY(BUSY),
    .KEEPER_EN(KEEPER_EN), .PREEMPT(PREEMPT), .VDD(VDD), .VSS(VSS));

  gf180mcu_fd_sc_mcu7t5v0__invz_bus_arb #(.N(8), .TURN(3), .MAX_HOLD(4)) dut2 (
    .CLK(CLK), .RN(RN), .REQ(REQ2), .EN(EN2), .GNT_ID(GNT_ID2), .BUSY(BUSY2),
    .KEEPER_EN(KEEPER2), .PREEMPT(PRE2), .VDD(VDD), .VSS(VSS));

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  typedef struct {
    int id;
    int len;
    bit pre;
    int gap;   // -1: gap not checked
  } grant_t;

  grant_t sb_q[$];

  task automatic push(input int id, input int len, input bit pre, input int gap);
    grant_t g;
    g.id = id; g.len = len; g.pre = pre; g.gap = gap;
    sb_q.push_back(g);
  endtask

  function automatic int oh2idx(input logic [3:0] v);
    for (int i = 3; i >= 0; i--) if (v[i]) oh2idx = i;
    if (v == '0) oh2idx = -1;
  endfunction

  // Grant monitor for the 4-way instance: one scoreboard entry per completed grant.
  bit         in_g = 1'b0;
  logic [3:0] cur_en;
  int         cur_len, cur_gap;
  int         gap   = -1;
  int         viol1 = 0;
  grant_t     g_exp;

  always @(negedge CLK) begin
    if (!$onehot0(EN)) viol1++;
    if (!RN) begin
      in_g = 1'b0;
      gap  = -1;
    end else if (EN != '0) begin
      if (!in_g) begin
        in_g    = 1'b1;
        cur_en  = EN;
        cur_len = 1;
        cur_gap = gap;
      end else begin
        if (EN != cur_en) chk("en_steady", EN, cur_en);
        cur_len++;
      end
    end else if (in_g) begin
      in_g = 1'b0;
      gap  = 1;
      if (sb_q.size() == 0) chk("sb_extra_grant", cur_en, 0);
      else begin
        g_exp = sb_q.pop_front();
        chk("grant_id", oh2idx(cur_en), g_exp.id);
        chk("grant_len", cur_len, g_exp.len);
        chk("grant_preempt", PREEMPT, g_exp.pre);
        if (g_exp.gap >= 0) chk("grant_gap", cur_gap, g_exp.gap);
      end
    end else if (gap >= 0) begin
      gap++;
    end
  end

  task automatic do_reset();
    @(negedge CLK);
    RN = 1'b0; REQ = '0; REQ2 = '0;
    repeat (2) @(negedge CLK);
    RN = 1'b1;
  endtask

  int         zeros, seen0, viol2, sw2, short_gap, maxw, grants, zero_run;
  logic [7:0] rise_en, prev2, nxt;
  int         waitc[8];

  initial begin
    // Reset state
    #1 RN = 1'b0;
    #2;
    chk("rst_en", EN, 4'b0000);
    chk("rst_gnt_id", GNT_ID, 0);
    chk("rst_busy", BUSY, 0);
    chk("rst_keeper", KEEPER_EN, 1);
    chk("rst_preempt", PREEMPT, 0);
    chk("rst_en2", EN2, 8'h00);
    @(negedge CLK);
    RN = 1'b1;

    // Single request, one-cycle latency
    push(2, 1, 1'b0, -1);
    REQ = 4'b0100;
    @(negedge CLK);
    chk("t1_en", EN, 4'b0100);
    chk("t1_busy", BUSY, 1);
    chk("t1_gnt_id", GNT_ID, 2);
    chk("t1_keeper", KEEPER_EN, 0);
    REQ = '0;
    repeat (3) @(negedge CLK);
    chk("t1_drain", sb_q.size(), 0);

    // All request, MAX_HOLD rotation 0,1,2,3,0 with preempt at each handoff
    do_reset();
    push(0, 16, 1'b1, -1);
    push(1, 16, 1'b1, 1);
    push(2, 16, 1'b1, 1);
    push(3, 16, 1'b1, 1);
    push(0, 16, 1'b1, 1);
    REQ = 4'b1111;
    repeat (85) @(negedge CLK);
    REQ = '0;
    repeat (5) @(negedge CLK);
    chk("t2_drain", sb_q.size(), 0);

    // Owner 1 releases after 5 cycles, pending 3 granted after one dead cycle
    do_reset();
    push(1, 5, 1'b0, -1);
    push(3, 3, 1'b0, 1);
    REQ = 4'b1010;
    repeat (5) @(negedge CLK);
    REQ = 4'b1000;
    @(negedge CLK);
    chk("t3_gap_en", EN, 4'b0000);
    chk("t3_gap_keeper", KEEPER_EN, 1);
    @(negedge CLK);
    chk("t3_next_en", EN, 4'b1000);
    chk("t3_next_keeper", KEEPER_EN, 0);
    chk("t3_next_gnt", GNT_ID, 3);
    repeat (2) @(negedge CLK);
    REQ = '0;
    repeat (4) @(negedge CLK);
    chk("t3_drain", sb_q.size(), 0);

    // Single requester: preempted, regranted, then release coinciding with expiry
    do_reset();
    push(0, 16, 1'b1, -1);
    push(0, 16, 1'b0, 1);
    REQ = 4'b0001;
    repeat (33) @(negedge CLK);
    REQ = '0;
    repeat (4) @(negedge CLK);
    chk("t6_drain", sb_q.size(), 0);

    // Asynchronous reset mid-DRIVE, then regrant from pointer 0
    do_reset();
    REQ = 4'b0100;
    repeat (3) @(negedge CLK);
    #3 RN = 1'b0;
    #1;
    chk("t5_rst_en", EN, 4'b0000);
    chk("t5_rst_keeper", KEEPER_EN, 1);
    chk("t5_rst_busy", BUSY, 0);
    chk("t5_rst_gnt", GNT_ID, 0);
    REQ = 4'b0110;
    @(negedge CLK);
    #2 RN = 1'b1;
    push(1, 1, 1'b0, -1);
    @(negedge CLK);
    chk("t5_regrant_en", EN, 4'b0010);
    chk("t5_regrant_gnt", GNT_ID, 1);
    REQ = '0;
    repeat (4) @(negedge CLK);
    chk("t5_drain", sb_q.size(), 0);

    // TURN=3: exactly three dead cycles between EN[0] falling and EN[1] rising
    do_reset();
    REQ2 = 8'b0000_0011;
    zeros = 0; seen0 = 0; rise_en = '0;
    for (int c = 0; c < 30 && rise_en == '0; c++) begin
      @(negedge CLK);
      if (EN2 == 8'b0000_0001) begin
        seen0++;
        if (seen0 == 2) REQ2[0] = 1'b0;
      end else if (EN2 == '0) begin
        if (seen0 > 0) zeros++;
      end else begin
        rise_en = EN2;
      end
    end
    chk("t4_gap", zeros, 3);
    chk("t4_next_en", rise_en, 8'b0000_0010);
    REQ2 = '0;
    repeat (6) @(negedge CLK);

    // Random requests on the 8-way instance
    do_reset();
    viol2 = 0; sw2 = 0; short_gap = 0; maxw = 0; grants = 0; zero_run = 100;
    prev2 = '0;
    for (int i = 0; i < 8; i++) waitc[i] = 0;
    for (int c = 0; c < 10000; c++) begin
      @(negedge CLK);
      if (!$onehot0(EN2)) viol2++;
      if (EN2 != '0 && prev2 != '0 && EN2 != prev2) sw2++;
      if (EN2 != '0 && prev2 == '0) begin
        grants++;
        if (zero_run < 3) short_gap++;
      end
      zero_run = (EN2 == '0) ? zero_run + 1 : 0;
      for (int i = 0; i < 8; i++) begin
        if (REQ2[i] && !EN2[i]) waitc[i]++;
        else waitc[i] = 0;
        if (waitc[i] > maxw) maxw = waitc[i];
      end
      nxt = REQ2;
      for (int i = 0; i < 8; i++) begin
        if (REQ2[i] && EN2[i]) begin
          if ($urandom_range(3) == 0) nxt[i] = 1'b0;
        end else if (!REQ2[i]) begin
          if ($urandom_range(3) == 0) nxt[i] = 1'b1;
        end
      end
      REQ2  = nxt;
      prev2 = EN2;
    end
    chk("t7_onehot", viol2, 0);
    chk("t7_direct_switch", sw2, 0);
    chk("t7_short_gap", short_gap, 0);
    chk("t7_wait_bound", (maxw <= 8 * (4 + 3)) ? 1 : 0, 1);
    chk("t7_active", (grants > 100) ? 1 : 0, 1);
    chk("t1_onehot", viol1, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
